// File: rtl/instr_fetch_ctrl.sv
// Fetch-stage controller: sequences a combinational word ROM, buffers {pc, instr} pairs in a
// small prefetch FIFO and presents them to decode over valid/ready, with redirect flush.
module instr_fetch_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_SIZE      = 512,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned RESET_PC      = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fetch_en,
  output logic [ADDRESS_WIDTH-1:0]       imem_addr,
  input  logic [DATA_WIDTH-1:0]          imem_data,
  input  logic                           redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]       redirect_pc,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_instr,
  output logic [ADDRESS_WIDTH-1:0]       out_pc,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           at_end,
  output logic                           misalign_err
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [AW-1:0] LAST_PC  = AW'(4 * MEM_SIZE - 4);
  localparam logic [AW-1:0] START_PC = AW'(RESET_PC);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    END  = 2'd2
  } state_t;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } entry_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  entry_t        fifo_mem [FIFO_DEPTH];

  logic          pop;
  logic          push;
  logic          full;
  logic [AW-1:0] redirect_target;
  logic          redirect_oor;

  assign redirect_target = {redirect_pc[AW-1:2], 2'b00};
  assign redirect_oor    = (redirect_target > LAST_PC);

  // Handshake, push qualification and next-state; redirect overrides every other transition.
  always_comb begin
    state_next = state;
    full       = (count == FULL_CNT);
    pop        = (count != '0) && out_ready;
    push       = (state == RUN) && fetch_en && !redirect_valid && (!full || pop);

    case (state)
      IDLE: begin
        if (fetch_en) state_next = RUN;
      end
      RUN: begin
        if (!fetch_en)                      state_next = IDLE;
        else if (push && fetch_pc == LAST_PC) state_next = END;
      end
      END: begin
        state_next = END;
      end
      default: state_next = IDLE;
    endcase

    if (redirect_valid) begin
      if (redirect_oor)  state_next = END;
      else if (fetch_en) state_next = RUN;
      else               state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fetch_pc     <= START_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        // An out-of-range target parks the PC where it was; nothing is fetched from there.
        if (!redirect_oor) fetch_pc <= redirect_target;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          if (fetch_pc != LAST_PC) fetch_pc <= fetch_pc + AW'(4);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage is not reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_data};
  end

  assign imem_addr  = fetch_pc;
  assign out_valid  = (count != '0);
  assign out_instr  = fifo_mem[rd_ptr].instr;
  assign out_pc     = fifo_mem[rd_ptr].pc;
  assign fifo_count = count;
  assign at_end     = (state == END);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl; the ROM model returns word index (addr/4) as data.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  fifo_count;
  logic        at_end;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_ctrl #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(512), .FIFO_DEPTH(4), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .fifo_count(fifo_count),
    .at_end(at_end), .misalign_err(misalign_err)
  );

  assign imem_data = {2'b00, imem_addr[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    do_reset();

    // Reset state
    check("rst_valid",   32'(out_valid), 32'd0);
    check("rst_at_end",  32'(at_end), 32'd0);
    check("rst_misal",   32'(misalign_err), 32'd0);
    check("rst_addr",    imem_addr, 32'h0);
    check("rst_count",   32'(fifo_count), 32'd0);

    // 1. Streaming: IDLE->RUN costs one edge, then one word per cycle
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    step();
    check("t1_idle_valid", 32'(out_valid), 32'd0);
    step();
    check("t1_pc0", out_pc, 32'h0);
    check("t1_instr0", out_instr, 32'h0);
    check("t1_cnt0", 32'(fifo_count), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t1_pc", out_pc, 32'(4 * k));
      check("t1_instr", out_instr, 32'(k));
      check("t1_cnt", 32'(fifo_count), 32'd1);
    end

    // 2. Backpressure saturates FIFO, then drains in order
    fetch_en  = 1'b0;
    out_ready = 1'b0;
    do_reset();
    fetch_en = 1'b1;
    step(10);
    check("t2_cnt_full", 32'(fifo_count), 32'd4);
    check("t2_addr_hold", imem_addr, 32'h10);
    check("t2_head", out_pc, 32'h0);
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t2_drain_pc", out_pc, 32'(4 * k));
      check("t2_drain_cnt", 32'(fifo_count), 32'd4);
    end

    // 3. Redirect with count=3 and a same-cycle pop flushes stale entries
    fetch_en = 1'b0;
    step();
    check("t3_cnt3", 32'(fifo_count), 32'd3);
    fetch_en       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("t3_flush_valid", 32'(out_valid), 32'd0);
    check("t3_flush_cnt", 32'(fifo_count), 32'd0);
    check("t3_addr", imem_addr, 32'h40);
    step();
    check("t3_pc", out_pc, 32'h40);
    check("t3_instr", out_instr, 32'h10);
    step();
    check("t3_pc_next", out_pc, 32'h44);

    // 4. Misaligned redirect drops low bits and pulses error for one cycle
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    redirect_valid = 1'b0;
    check("t4_misal", 32'(misalign_err), 32'd1);
    check("t4_addr", imem_addr, 32'h40);
    check("t4_valid", 32'(out_valid), 32'd0);
    step();
    check("t4_misal_clr", 32'(misalign_err), 32'd0);
    check("t4_pc", out_pc, 32'h40);

    // 5. End of ROM, then recover with redirect to 0
    redirect_valid = 1'b1;
    redirect_pc    = 32'h7F8;
    step();
    redirect_valid = 1'b0;
    check("t5_addr", imem_addr, 32'h7F8);
    step();
    check("t5_pc_7f8", out_pc, 32'h7F8);
    check("t5_not_end", 32'(at_end), 32'd0);
    step();
    check("t5_pc_7fc", out_pc, 32'h7FC);
    check("t5_at_end", 32'(at_end), 32'd1);
    check("t5_addr_hold", imem_addr, 32'h7FC);
    step();
    check("t5_empty", 32'(out_valid), 32'd0);
    step();
    check("t5_no_push", 32'(fifo_count), 32'd0);
    check("t5_addr_hold2", imem_addr, 32'h7FC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    redirect_valid = 1'b0;
    check("t5_run", 32'(at_end), 32'd0);
    check("t5_addr0", imem_addr, 32'h0);
    step();
    check("t5_pc0", out_pc, 32'h0);

    // 5b. Out-of-range redirect goes straight to END, FIFO flushed
    redirect_valid = 1'b1;
    redirect_pc    = 32'h800;
    step();
    redirect_valid = 1'b0;
    check("t5b_end", 32'(at_end), 32'd1);
    check("t5b_cnt", 32'(fifo_count), 32'd0);
    step();
    check("t5b_no_push", 32'(fifo_count), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    step();
    redirect_valid = 1'b0;
    step();
    check("t5b_recover", out_pc, 32'h8);

    // 6. Reset mid-stream with a full FIFO
    out_ready = 1'b0;
    step(6);
    check("t6_full", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst      = 1'b0;
    fetch_en = 1'b0;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_addr", imem_addr, 32'h0);
    check("t6_cnt", 32'(fifo_count), 32'd0);
    step(3);
    check("t6_idle_valid", 32'(out_valid), 32'd0);
    check("t6_idle_addr", imem_addr, 32'h0);
    fetch_en = 1'b1;
    step();
    check("t6_first_edge", 32'(out_valid), 32'd0);
    step();
    check("t6_pc0", out_pc, 32'h0);
    check("t6_cnt1", 32'(fifo_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
